// File: rtl/execution_sequencer.sv
// Command sequencer: runs optional authorization, one functional unit and optional
// NVM commit for each accepted command, then reports a one-cycle success/failure pulse.
module execution_sequencer #(
  parameter int NUM_UNITS      = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_unit,
  input  logic                 cmd_auth_req,
  input  logic                 cmd_nvm_req,
  output logic                 start_auth_check,
  input  logic                 auth_success,
  input  logic                 auth_fail,
  output logic [NUM_UNITS-1:0] unit_start,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  logic [NUM_UNITS-1:0] unit_fail,
  output logic                 start_nvm_op,
  input  logic                 nvm_success,
  input  logic                 nvm_fail,
  output logic                 command_succeeded,
  output logic                 command_failed,
  output logic [2:0]           err_code
);

  typedef enum logic [2:0] {
    IDLE, DECODE, AUTH_WAIT, EXEC_WAIT, NVM_WAIT, FINISH
  } state_t;

  typedef enum logic [2:0] {
    E_OK = 3'd0, E_BAD_UNIT = 3'd1, E_AUTH = 3'd2, E_UNIT = 3'd3, E_NVM = 3'd4, E_TIMEOUT = 3'd5
  } err_t;

  localparam int          TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit          T_EN   = (TIMEOUT_CYCLES != 0);

  state_t              state_q, state_n;
  logic [2:0]          unit_q, unit_n;
  logic                auth_q, auth_n;
  logic                nvm_q, nvm_n;
  logic [TW-1:0]       timer_q, timer_n;
  err_t                err_q, err_n;

  logic                cmd_ready_n, start_auth_n, start_nvm_n, succ_n, fail_n;
  logic [NUM_UNITS-1:0] unit_start_n;

  logic [NUM_UNITS-1:0] sel;
  logic                unit_valid, unit_hit_done, unit_hit_fail, timeout;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++)
      sel[i] = ({29'd0, unit_q} == (i + 32'd1));
  end

  assign unit_valid    = ({29'd0, unit_q} <= 32'(NUM_UNITS));
  assign unit_hit_done = |(unit_done & sel);
  assign unit_hit_fail = |(unit_fail & sel);
  assign timeout       = T_EN && (timer_q == T_LAST);

  always_comb begin
    state_n = state_q;
    unit_n  = unit_q;
    auth_n  = auth_q;
    nvm_n   = nvm_q;
    timer_n = timer_q;
    err_n   = err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          unit_n  = cmd_unit;
          auth_n  = cmd_auth_req;
          nvm_n   = cmd_nvm_req;
          err_n   = E_OK;
          state_n = DECODE;
        end
      end
      DECODE: begin
        if (!unit_valid) begin
          err_n   = E_BAD_UNIT;
          state_n = FINISH;
        end else if (auth_q)       state_n = AUTH_WAIT;
        else if (unit_q != 3'd0)   state_n = EXEC_WAIT;
        else if (nvm_q)            state_n = NVM_WAIT;
        else                       state_n = FINISH;
      end
      AUTH_WAIT: begin
        if (auth_fail) begin
          err_n   = E_AUTH;
          state_n = FINISH;
        end else if (auth_success) begin
          if (unit_q != 3'd0) state_n = EXEC_WAIT;
          else if (nvm_q)     state_n = NVM_WAIT;
          else                state_n = FINISH;
        end else if (timeout) begin
          err_n   = E_TIMEOUT;
          state_n = FINISH;
        end else timer_n = timer_q + TW'(1);
      end
      EXEC_WAIT: begin
        if (unit_hit_fail) begin
          err_n   = E_UNIT;
          state_n = FINISH;
        end else if (unit_hit_done) begin
          state_n = nvm_q ? NVM_WAIT : FINISH;
        end else if (timeout) begin
          err_n   = E_TIMEOUT;
          state_n = FINISH;
        end else timer_n = timer_q + TW'(1);
      end
      NVM_WAIT: begin
        if (nvm_fail) begin
          err_n   = E_NVM;
          state_n = FINISH;
        end else if (nvm_success) begin
          state_n = FINISH;
        end else if (timeout) begin
          err_n   = E_TIMEOUT;
          state_n = FINISH;
        end else timer_n = timer_q + TW'(1);
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n != state_q) timer_n = '0;

    // Outputs are computed for the state being entered so they register alongside it.
    cmd_ready_n  = (state_n == IDLE);
    start_auth_n = (state_n == AUTH_WAIT) && (state_q != AUTH_WAIT);
    start_nvm_n  = (state_n == NVM_WAIT)  && (state_q != NVM_WAIT);
    unit_start_n = ((state_n == EXEC_WAIT) && (state_q != EXEC_WAIT)) ? sel : '0;
    succ_n       = (state_n == FINISH) && (err_n == E_OK);
    fail_n       = (state_n == FINISH) && (err_n != E_OK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      unit_q            <= '0;
      auth_q            <= 1'b0;
      nvm_q             <= 1'b0;
      timer_q           <= '0;
      err_q             <= E_OK;
      cmd_ready         <= 1'b1;
      start_auth_check  <= 1'b0;
      unit_start        <= '0;
      start_nvm_op      <= 1'b0;
      command_succeeded <= 1'b0;
      command_failed    <= 1'b0;
    end else begin
      state_q           <= state_n;
      unit_q            <= unit_n;
      auth_q            <= auth_n;
      nvm_q             <= nvm_n;
      timer_q           <= timer_n;
      err_q             <= err_n;
      cmd_ready         <= cmd_ready_n;
      start_auth_check  <= start_auth_n;
      unit_start        <= unit_start_n;
      start_nvm_op      <= start_nvm_n;
      command_succeeded <= succ_n;
      command_failed    <= fail_n;
    end
  end

  assign err_code = err_q;

endmodule
